lenet_feeder: RTL



---
 rtl/lenet_feeder.sv | 111 +++++++++++
 1 files changed

// File: rtl/lenet_feeder.sv
// Streams the 32x32 padded LeNet input buffer to the CNN over valid/ready,
// zeroing the PAD-wide border and counting data_ready pulses dropped mid-frame.
module lenet_feeder #(
  parameter int IMG_DIM = 32,
  parameter int PAD     = 2,
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 10
) (
  input  logic              clk25,
  input  logic              rst_n,
  input  logic              data_ready,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic              frame_done,
  output logic [7:0]        overrun_cnt
);

  localparam int unsigned     DIM_W    = $clog2(IMG_DIM);
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(IMG_DIM*IMG_DIM-1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   issue_cnt;
  logic              inflight_q, infl_border_q, infl_last_q;
  logic [DATA_W-1:0] fifo_data [2];
  logic              fifo_last [2];
  logic              wr_ptr, rd_ptr;
  logic [1:0]        occ;
  logic [2:0]        level;
  logic              pop, issue_last, border;
  logic [DIM_W-1:0]  row, col;

  assign m_valid = (occ != 2'd0);
  assign pop     = m_valid && m_ready;
  assign m_data  = fifo_data[rd_ptr];
  assign m_last  = m_valid && fifo_last[rd_ptr];
  assign busy    = (state_q != IDLE);
  assign rd_addr = issue_cnt[ADDR_W-1:0];

  // Border tag is computed at issue time and rides alongside the read.
  assign row        = issue_cnt[2*DIM_W-1:DIM_W];
  assign col        = issue_cnt[DIM_W-1:0];
  assign border     = (row < DIM_W'(PAD)) || (row >= DIM_W'(IMG_DIM-PAD)) ||
                      (col < DIM_W'(PAD)) || (col >= DIM_W'(IMG_DIM-PAD));
  assign issue_last = (issue_cnt == LAST_IDX);

  // Occupancy the FIFO will have after this edge, counting the read in flight.
  assign level = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};

  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (data_ready) state_d = RUN;
      end
      RUN: begin
        rd_en = (level < 3'd2);
        if (rd_en && issue_last) state_d = DRAIN;
      end
      DRAIN: begin
        if (pop && m_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      issue_cnt     <= '0;
      inflight_q    <= 1'b0;
      infl_border_q <= 1'b0;
      infl_last_q   <= 1'b0;
      wr_ptr        <= 1'b0;
      rd_ptr        <= 1'b0;
      occ           <= '0;
      frame_done    <= 1'b0;
      overrun_cnt   <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_last[i] <= 1'b0;
      end
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && data_ready) issue_cnt <= '0;
      else if (rd_en)                    issue_cnt <= issue_cnt + 1'b1;
      inflight_q    <= rd_en;
      infl_border_q <= border;
      infl_last_q   <= issue_last;
      if (inflight_q) begin
        fifo_data[wr_ptr] <= infl_border_q ? '0 : rd_data;
        fifo_last[wr_ptr] <= infl_last_q;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      occ        <= level[1:0];
      frame_done <= (state_q == DRAIN) && pop && m_last;
      if (data_ready && state_q != IDLE && overrun_cnt != 8'hFF)
        overrun_cnt <= overrun_cnt + 8'd1;
    end
  end

endmodule
